// File: rtl/vlsu_axi_txn_limiter.sv
// Outstanding-burst limiter between the VLSU AXI master and the memory-side cut.
// Caps AR/AW in flight, holds W until its AW is accepted, tracks error responses, drains on request.
module vlsu_axi_txn_limiter #(
   parameter int unsigned MaxRdTxn = 8,
   parameter int unsigned MaxWrTxn = 8,
   parameter int unsigned RdCntW   = $clog2(MaxRdTxn + 1),
   parameter int unsigned WrCntW   = $clog2(MaxWrTxn + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              slv_ar_valid_i,
   output logic              slv_ar_ready_o,
   output logic              mst_ar_valid_o,
   input  logic              mst_ar_ready_i,
   input  logic              slv_aw_valid_i,
   output logic              slv_aw_ready_o,
   output logic              mst_aw_valid_o,
   input  logic              mst_aw_ready_i,
   input  logic              slv_w_valid_i,
   output logic              slv_w_ready_o,
   input  logic              slv_w_last_i,
   output logic              mst_w_valid_o,
   input  logic              mst_w_ready_i,
   input  logic              mst_r_valid_i,
   output logic              mst_r_ready_o,
   input  logic              mst_r_last_i,
   input  logic [1:0]        mst_r_resp_i,
   output logic              slv_r_valid_o,
   input  logic              slv_r_ready_i,
   input  logic              mst_b_valid_i,
   output logic              mst_b_ready_o,
   input  logic [1:0]        mst_b_resp_i,
   output logic              slv_b_valid_o,
   input  logic              slv_b_ready_i,
   input  logic              drain_req_i,
   output logic              drain_done_o,
   output logic              rd_err_o,
   output logic              wr_err_o,
   input  logic              err_clr_i,
   output logic [RdCntW-1:0] rd_outstanding_o,
   output logic [WrCntW-1:0] wr_outstanding_o
);

   typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

   localparam logic [RdCntW-1:0] RdMax = RdCntW'(MaxRdTxn);
   localparam logic [WrCntW-1:0] WrMax = WrCntW'(MaxWrTxn);

   state_t            state_q, state_d;
   logic [RdCntW-1:0] rd_cnt_q;
   logic [WrCntW-1:0] wr_cnt_q;
   logic [WrCntW-1:0] w_pend_q;
   logic              rd_err_q, wr_err_q;

   logic ar_open, aw_open, w_open;
   logic ar_hs, aw_hs, w_last_hs, r_hs, r_last_hs, b_hs;
   logic unused_resp;

   // Gates look only at registered state, so R/B never reach AR/AW combinationally.
   assign ar_open = (rd_cnt_q != RdMax) && (state_q == IDLE);
   assign aw_open = (wr_cnt_q != WrMax) && (state_q == IDLE);
   assign w_open  = (w_pend_q != '0);

   assign mst_ar_valid_o = slv_ar_valid_i & ar_open;
   assign slv_ar_ready_o = mst_ar_ready_i & ar_open;
   assign mst_aw_valid_o = slv_aw_valid_i & aw_open;
   assign slv_aw_ready_o = mst_aw_ready_i & aw_open;
   assign mst_w_valid_o  = slv_w_valid_i & w_open;
   assign slv_w_ready_o  = mst_w_ready_i & w_open;

   assign slv_r_valid_o = mst_r_valid_i;
   assign mst_r_ready_o = slv_r_ready_i;
   assign slv_b_valid_o = mst_b_valid_i;
   assign mst_b_ready_o = slv_b_ready_i;

   assign ar_hs     = slv_ar_valid_i & mst_ar_ready_i & ar_open;
   assign aw_hs     = slv_aw_valid_i & mst_aw_ready_i & aw_open;
   assign w_last_hs = slv_w_valid_i & mst_w_ready_i & w_open & slv_w_last_i;
   assign r_hs      = mst_r_valid_i & slv_r_ready_i;
   assign r_last_hs = r_hs & mst_r_last_i;
   assign b_hs      = mst_b_valid_i & slv_b_ready_i;

   assign unused_resp = ^{mst_r_resp_i[0], mst_b_resp_i[0]};

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (drain_req_i) state_d = DRAIN;
         DRAIN: begin
            if (!drain_req_i)
               state_d = IDLE;
            else if (rd_cnt_q == '0 && wr_cnt_q == '0 && w_pend_q == '0)
               state_d = DONE;
         end
         DONE:  if (!drain_req_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         w_pend_q <= '0;
         rd_err_q <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         state_q <= state_d;

         // Decrement at zero is a protocol error; the counters saturate instead of wrapping.
         if (ar_hs && !r_last_hs)
            rd_cnt_q <= rd_cnt_q + RdCntW'(1);
         else if (!ar_hs && r_last_hs && rd_cnt_q != '0)
            rd_cnt_q <= rd_cnt_q - RdCntW'(1);

         if (aw_hs && !b_hs)
            wr_cnt_q <= wr_cnt_q + WrCntW'(1);
         else if (!aw_hs && b_hs && wr_cnt_q != '0)
            wr_cnt_q <= wr_cnt_q - WrCntW'(1);

         if (aw_hs && !w_last_hs)
            w_pend_q <= w_pend_q + WrCntW'(1);
         else if (!aw_hs && w_last_hs)
            w_pend_q <= w_pend_q - WrCntW'(1);

         if (r_hs && mst_r_resp_i[1])
            rd_err_q <= 1'b1;
         else if (err_clr_i)
            rd_err_q <= 1'b0;

         if (b_hs && mst_b_resp_i[1])
            wr_err_q <= 1'b1;
         else if (err_clr_i)
            wr_err_q <= 1'b0;
      end
   end

   assign drain_done_o     = (state_q == DONE);
   assign rd_err_o         = rd_err_q;
   assign wr_err_o         = wr_err_q;
   assign rd_outstanding_o = rd_cnt_q;
   assign wr_outstanding_o = wr_cnt_q;

   a_rd_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(r_last_hs && !ar_hs && rd_cnt_q == '0));
   a_wr_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(b_hs && !aw_hs && wr_cnt_q == '0));

endmodule

// File: tb/tb_vlsu_axi_txn_limiter.sv
// Scoreboard bench for vlsu_axi_txn_limiter: directed scenarios followed by constrained-random traffic.
module tb_vlsu_axi_txn_limiter;

   localparam int RD_MAX = 8;
   localparam int WR_MAX = 8;
   localparam int RDW = $clog2(RD_MAX + 1);
   localparam int WRW = $clog2(WR_MAX + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_last, w_ready;
   logic r_valid, r_last, r_ready, b_valid, b_ready, drain_req, err_clr;
   logic [1:0] r_resp, b_resp;
   logic slv_ar_ready, mst_ar_valid, slv_aw_ready, mst_aw_valid, slv_w_ready, mst_w_valid;
   logic mst_r_ready, slv_r_valid, mst_b_ready, slv_b_valid, drain_done, rd_err, wr_err;
   logic [RDW-1:0] rd_out;
   logic [WRW-1:0] wr_out;

   vlsu_axi_txn_limiter #(.MaxRdTxn(RD_MAX), .MaxWrTxn(WR_MAX)) dut (
      .clk_i(clk), .rst_i(rst),
      .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(slv_ar_ready),
      .mst_ar_valid_o(mst_ar_valid), .mst_ar_ready_i(ar_ready),
      .slv_aw_valid_i(aw_valid), .slv_aw_ready_o(slv_aw_ready),
      .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(aw_ready),
      .slv_w_valid_i(w_valid), .slv_w_ready_o(slv_w_ready), .slv_w_last_i(w_last),
      .mst_w_valid_o(mst_w_valid), .mst_w_ready_i(w_ready),
      .mst_r_valid_i(r_valid), .mst_r_ready_o(mst_r_ready), .mst_r_last_i(r_last),
      .mst_r_resp_i(r_resp), .slv_r_valid_o(slv_r_valid), .slv_r_ready_i(r_ready),
      .mst_b_valid_i(b_valid), .mst_b_ready_o(mst_b_ready), .mst_b_resp_i(b_resp),
      .slv_b_valid_o(slv_b_valid), .slv_b_ready_i(b_ready),
      .drain_req_i(drain_req), .drain_done_o(drain_done),
      .rd_err_o(rd_err), .wr_err_o(wr_err), .err_clr_i(err_clr),
      .rd_outstanding_o(rd_out), .wr_outstanding_o(wr_out)
   );

   typedef struct packed {
      logic rst, ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_last, w_ready;
      logic r_valid, r_last; logic [1:0] r_resp; logic r_ready;
      logic b_valid; logic [1:0] b_resp; logic b_ready;
      logic drain_req, err_clr;
   } stim_t;

   typedef struct {
      logic [5:0] gates;   // {mst_ar_valid, slv_ar_ready, mst_aw_valid, slv_aw_ready, mst_w_valid, slv_w_ready}
      logic [3:0] pass;    // {slv_r_valid, mst_r_ready, slv_b_valid, mst_b_ready}
      logic [2:0] status;  // {drain_done, rd_err, wr_err}
      int rd;
      int wr;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int tests = 0;
   int fails = 0;

   // Reference model: outstanding bursts, AWs still owed their W data, sticky errors, drain phase.
   int m_rd = 0, m_wr = 0, m_wpend = 0;
   bit m_rerr = 0, m_werr = 0, m_known = 0;
   int m_phase = 0;  // 0 running, 1 waiting for traffic to retire, 2 quiesced
   bit drain_hold = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("gates", int'({mst_ar_valid, slv_ar_ready, mst_aw_valid, slv_aw_ready, mst_w_valid, slv_w_ready}),
             int'(mon_e.gates));
         chk("passthru", int'({slv_r_valid, mst_r_ready, slv_b_valid, mst_b_ready}), int'(mon_e.pass));
         chk("status", int'({drain_done, rd_err, wr_err}), int'(mon_e.status));
         chk("rd_outstanding", int'(rd_out), mon_e.rd);
         chk("wr_outstanding", int'(wr_out), mon_e.wr);
      end
   end

   task automatic cycle(input stim_t s);
      exp_t e;
      bit ar_ok, aw_ok, w_ok, ar_fire, aw_fire, wl_fire, r_fire, rl_fire, b_fire, quiet;
      @(posedge clk);
      #1;
      rst = s.rst; ar_valid = s.ar_valid; ar_ready = s.ar_ready;
      aw_valid = s.aw_valid; aw_ready = s.aw_ready;
      w_valid = s.w_valid; w_last = s.w_last; w_ready = s.w_ready;
      r_valid = s.r_valid; r_last = s.r_last; r_resp = s.r_resp; r_ready = s.r_ready;
      b_valid = s.b_valid; b_resp = s.b_resp; b_ready = s.b_ready;
      drain_req = s.drain_req; err_clr = s.err_clr;

      ar_ok = (m_phase == 0) && (m_rd < RD_MAX);
      aw_ok = (m_phase == 0) && (m_wr < WR_MAX);
      w_ok  = (m_wpend > 0);
      e.gates  = {s.ar_valid & ar_ok, s.ar_ready & ar_ok, s.aw_valid & aw_ok, s.aw_ready & aw_ok,
                  s.w_valid & w_ok, s.w_ready & w_ok};
      e.pass   = {s.r_valid, s.r_ready, s.b_valid, s.b_ready};
      e.status = {m_phase == 2, m_rerr, m_werr};
      e.rd     = m_rd;
      e.wr     = m_wr;
      if (m_known) exp_q.push_back(e);

      ar_fire = s.ar_valid && s.ar_ready && ar_ok;
      aw_fire = s.aw_valid && s.aw_ready && aw_ok;
      wl_fire = s.w_valid && s.w_ready && w_ok && s.w_last;
      r_fire  = s.r_valid && s.r_ready;
      rl_fire = r_fire && s.r_last;
      b_fire  = s.b_valid && s.b_ready;
      quiet   = (m_rd == 0) && (m_wr == 0) && (m_wpend == 0);

      if (s.rst) begin
         m_rd = 0; m_wr = 0; m_wpend = 0; m_rerr = 0; m_werr = 0; m_phase = 0; m_known = 1;
      end else begin
         m_rd = m_rd + int'(ar_fire) - int'(rl_fire);
         if (m_rd < 0) m_rd = 0;
         m_wr = m_wr + int'(aw_fire) - int'(b_fire);
         if (m_wr < 0) m_wr = 0;
         m_wpend = m_wpend + int'(aw_fire) - int'(wl_fire);
         if (r_fire && s.r_resp[1]) m_rerr = 1; else if (s.err_clr) m_rerr = 0;
         if (b_fire && s.b_resp[1]) m_werr = 1; else if (s.err_clr) m_werr = 0;
         if (!s.drain_req) m_phase = 0;
         else if (m_phase == 0) m_phase = 1;
         else if (m_phase == 1 && quiet) m_phase = 2;
      end
   endtask

   initial begin
      stim_t s;
      int rpct, bpct;

      s = '0; s.rst = 1;
      cycle(s); cycle(s);

      // Fill the read side with no responses: the cap must stop AR after 8.
      s = '0; s.ar_valid = 1; s.ar_ready = 1;
      repeat (10) cycle(s);
      s.r_valid = 1; s.r_last = 1; s.r_ready = 1;
      cycle(s);
      s.r_valid = 0; s.r_last = 0; s.r_ready = 0;
      repeat (2) cycle(s);

      // Retire down to 3, then AR and R-last together.
      s = '0; s.r_valid = 1; s.r_last = 1; s.r_ready = 1;
      repeat (5) cycle(s);
      s.ar_valid = 1; s.ar_ready = 1;
      cycle(s);
      s = '0; cycle(s);

      // W before any AW, then AW, then W last.
      s = '0; s.w_valid = 1; s.w_ready = 1; s.w_last = 1;
      cycle(s);
      s.aw_valid = 1; s.aw_ready = 1;
      cycle(s);
      s.aw_valid = 0; s.aw_ready = 0;
      cycle(s); cycle(s);

      // Write error set and clear in the same cycle, then clear alone.
      s = '0; s.b_valid = 1; s.b_ready = 1; s.b_resp = 2'b10; s.err_clr = 1;
      cycle(s);
      s = '0; s.err_clr = 1; cycle(s);
      s = '0; cycle(s);

      // Drain with two reads and one write in flight.
      s = '0; s.r_valid = 1; s.r_last = 1; s.r_ready = 1; s.aw_valid = 1; s.aw_ready = 1;
      cycle(s);
      s = '0; s.w_valid = 1; s.w_last = 1; s.w_ready = 1;
      cycle(s);
      s = '0; s.drain_req = 1;
      cycle(s);
      s.ar_valid = 1; s.ar_ready = 1; s.aw_valid = 1; s.aw_ready = 1;
      repeat (2) cycle(s);
      s.r_valid = 1; s.r_last = 1; s.r_ready = 1;
      repeat (2) cycle(s);
      s.r_valid = 0; s.r_last = 0; s.r_ready = 0; s.b_valid = 1; s.b_ready = 1;
      cycle(s);
      s.b_valid = 0; s.b_ready = 0;
      repeat (3) cycle(s);
      s.drain_req = 0;
      repeat (2) cycle(s);

      // Random traffic alternating between filling and retiring phases.
      for (int i = 0; i < 3000; i++) begin
         rpct = ((i / 300) % 2 == 0) ? 15 : 70;
         bpct = rpct;
         s = '0;
         s.ar_valid = ($urandom_range(0, 3) != 0);
         s.ar_ready = ($urandom_range(0, 3) != 0);
         s.aw_valid = ($urandom_range(0, 3) != 0);
         s.aw_ready = ($urandom_range(0, 3) != 0);
         s.w_valid  = ($urandom_range(0, 2) != 0);
         s.w_last   = ($urandom_range(0, 1) != 0);
         s.w_ready  = ($urandom_range(0, 3) != 0);
         s.r_valid  = (m_rd > 0) && ($urandom_range(0, 99) < rpct);
         s.r_last   = ($urandom_range(0, 1) != 0);
         s.r_resp   = 2'($urandom_range(0, 3));
         s.r_ready  = ($urandom_range(0, 3) != 0);
         s.b_valid  = (m_wr > m_wpend) && ($urandom_range(0, 99) < bpct);
         s.b_resp   = 2'($urandom_range(0, 3));
         s.b_ready  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 59) == 0) drain_hold = !drain_hold;
         s.drain_req = drain_hold;
         s.err_clr  = ($urandom_range(0, 15) == 0);
         s.rst      = ($urandom_range(0, 499) == 0);
         cycle(s);
      end

      s = '0; cycle(s);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vlsu_axi_txn_limiter.md
Name: vlsu_axi_txn_limiter

Overview:
- Sits between the VLSU AXI master port and the memory-side AXI cut.
- Passes AXI handshakes through combinationally and caps the number of outstanding read and write bursts.
- Enforces W-after-AW ordering and tracks error responses.
- Provides a drain FSM so the dispatcher can quiesce vector memory traffic before a flush or fence.
- Payload fields (AR/AW/W/R/B structs) are wired around this block; only valid/ready/last/resp pass through it.

Parameters:
- MaxRdTxn, 8, maximum outstanding AR bursts (no final R last seen yet); must be >=1.
- MaxWrTxn, 8, maximum outstanding AW bursts (no B seen yet); must be >=1.
- RdCntW, $clog2(MaxRdTxn+1), derived; do not override.
- WrCntW, $clog2(MaxWrTxn+1), derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- slv_ar_valid_i / slv_ar_ready_o  in/out  1  AR handshake from VLSU
- mst_ar_valid_o / mst_ar_ready_i  out/in  1  AR handshake to memory
- slv_aw_valid_i / slv_aw_ready_o  in/out  1  AW handshake from VLSU
- mst_aw_valid_o / mst_aw_ready_i  out/in  1  AW handshake to memory
- slv_w_valid_i / slv_w_ready_o  in/out  1  W handshake from VLSU
- slv_w_last_i  in  1  W last beat
- mst_w_valid_o / mst_w_ready_i  out/in  1  W handshake to memory
- mst_r_valid_i / mst_r_ready_o  in/out  1  R handshake from memory
- mst_r_last_i  in  1  R last beat
- mst_r_resp_i  in  2  R response
- slv_r_valid_o / slv_r_ready_i  out/in  1  R handshake to VLSU
- mst_b_valid_i / mst_b_ready_o  in/out  1  B handshake from memory
- mst_b_resp_i  in  2  B response
- slv_b_valid_o / slv_b_ready_i  out/in  1  B handshake to VLSU
- drain_req_i  in  1  request quiesce
- drain_done_o  out  1  all traffic retired while draining
- rd_err_o  out  1  sticky: R resp[1]==1 seen
- wr_err_o  out  1  sticky: B resp[1]==1 seen
- err_clr_i  in  1  clear both sticky errors
- rd_outstanding_o  out  RdCntW  current read counter
- wr_outstanding_o  out  WrCntW  current write counter

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - All counters are 0; error flags are 0; FSM goes to IDLE.
  - drain_done_o is 0.
  - Reset mid-burst discards all state; no completion is reported afterwards.
- AR gating: ar_open = (rd_cnt != MaxRdTxn) && (state == IDLE).
  - mst_ar_valid_o = slv_ar_valid_i & ar_open.
  - slv_ar_ready_o = mst_ar_ready_i & ar_open.
  - The gate depends only on registered state; there is no combinational path from R/B to AR/AW.
  - At full, an R-last retiring in the same cycle does not open the gate until the next cycle.
- AW gating: identical to AR, using wr_cnt and MaxWrTxn.
- Read counter:
  - +1 on an AR handshake.
  - -1 on an R handshake (mst_r_valid_i & slv_r_ready_i) with mst_r_last_i.
  - Simultaneous +1/-1 leaves the counter unchanged.
  - Decrement at 0 is a protocol error: the counter holds at 0 and an assertion fires.
- Write counter: +1 on an AW handshake, -1 on a B handshake; same simultaneous and underflow rules as the read counter.
- W ordering:
  - w_pend counter (WrCntW bits): +1 on an AW handshake, -1 on a W handshake with slv_w_last_i.
  - w_open = (w_pend != 0).
  - mst_w_valid_o = slv_w_valid_i & w_open; slv_w_ready_o = mst_w_ready_i & w_open.
  - An AW and its first W may not complete in the same cycle; W opens one cycle after the AW handshake.
- R/B pass-through:
  - slv_r_valid_o = mst_r_valid_i; mst_r_ready_o = slv_r_ready_i.
  - B channel is wired the same way.
  - No buffering on R/B; zero latency.
- Errors:
  - rd_err_o is set on an R handshake with mst_r_resp_i[1].
  - wr_err_o is set on a B handshake with mst_b_resp_i[1].
  - err_clr_i clears both flags next cycle; if set and clear occur in the same cycle, set wins.
- Drain FSM (states IDLE, DRAIN, DONE):
  - IDLE -> DRAIN when drain_req_i=1. AR/AW close from the next cycle; an AR/AW already handshaken in that cycle is counted.
  - DRAIN -> DONE when rd_cnt==0, wr_cnt==0 and w_pend==0. This may happen the cycle after entry if the unit is already idle.
  - In DONE, drain_done_o=1 (registered output, high only in DONE).
  - DONE -> IDLE when drain_req_i=0. If drain_req_i drops during DRAIN, the FSM returns to IDLE and drain_done_o stays 0.
  - W, R and B remain open in DRAIN so that in-flight traffic retires.

Test Plan:
- Reset with rst_i=1 for 2 cycles, then slv_ar_valid_i=1 and mst_ar_ready_i=1 for 10 cycles with no R -> exactly 8 AR handshakes, rd_outstanding_o=8, slv_ar_ready_o=0 from cycle 9.
- At rd_cnt=8, one R beat with last=1 while slv_ar_valid_i=1 -> rd_outstanding_o=7 next cycle; AR handshake occurs the cycle after; count returns to 8.
- Same cycle AR handshake and R-last at rd_cnt=3 -> rd_outstanding_o stays 3.
- W asserted before any AW -> mst_w_valid_o=0. AW handshake at cycle t -> W passes at t+1; W last -> w_pend=0 and W closes again.
- B with resp=2'b10 and err_clr_i=1 in the same cycle -> wr_err_o=1; err_clr_i alone next cycle -> wr_err_o=0.
- drain_req_i=1 with rd_cnt=2 and wr_cnt=1 -> AR/AW blocked. After 2 R-lasts and 1 B, drain_done_o=1 one cycle after the final retire. Deassert drain_req_i -> IDLE, drain_done_o=0.
